enemy_shot_ctrl: RTL and testbench

Consumer side of the enemy-fire selection: takes the shooter chosen by `engine` (`ID_enemy_tiro_X`/`ID_enemy_tiro_Y`), launches one enemy projectile from that invader's position, moves it down the screen, and detects hits on the player. It maintains the player's lives and drives `jogador_vivo` back into `engine`. It sits between `engine`, the invader formation block (which supplies the formation origin) and the renderer (which consumes the shot position).

---
 rtl/game_pkg.sv | 18 +
 rtl/tick_divider.sv | 29 ++
 rtl/enemy_shot_ctrl.sv | 151 +++++++++++++++
 tb/tb_enemy_shot_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: enemy-shot state encoding and the screen/player
// geometry used by the player, renderer and enemy-fire blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        HIT,
        DEAD
    } shot_state_t;

    localparam int GAME_SCREEN_W = 640;
    localparam int GAME_SCREEN_H = 480;
    localparam int GAME_PLAYER_Y = 440;
    localparam int GAME_PLAYER_W = 32;
    localparam int GAME_PLAYER_H = 16;

endpackage

// File: rtl/tick_divider.sv
// Free-running motion-tick generator: tick is high for one clock every
// TICK_DIV clocks, on the cycle the counter sits at TICK_DIV-1.
module tick_divider #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/enemy_shot_ctrl.sv
// Enemy projectile controller: spawns one shot from the selected invader,
// marches it down the screen, detects player hits and tracks remaining lives.
module enemy_shot_ctrl
    import game_pkg::*;
#(
    parameter int WIDTH     = 65,
    parameter int COLS      = 13,
    parameter int ROWS      = 5,
    parameter int SPACING_X = 40,
    parameter int SPACING_Y = 32,
    parameter int ENEMY_W   = 24,
    parameter int ENEMY_H   = 16,
    parameter int SHOT_W    = 2,
    parameter int SHOT_H    = 8,
    parameter int SHOT_STEP = 4,
    parameter int TICK_DIV  = 250000,
    parameter int SCREEN_H  = GAME_SCREEN_H,
    parameter int PLAYER_Y  = GAME_PLAYER_Y,
    parameter int PLAYER_W  = GAME_PLAYER_W,
    parameter int PLAYER_H  = GAME_PLAYER_H,
    parameter int LIVES     = 3,
    parameter int HIT_HOLD  = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [WIDTH-1:0] enemy_vivos,
    input  logic [5:0]       ID_enemy_tiro_X,
    input  logic [5:0]       ID_enemy_tiro_Y,
    input  logic [9:0]       form_x,
    input  logic [9:0]       form_y,
    input  logic [9:0]       player_x,
    output logic             shot_active,
    output logic [9:0]       shot_x,
    output logic [9:0]       shot_y,
    output logic             hit_pulse,
    output logic [1:0]       lives,
    output logic             jogador_vivo
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = $clog2(HIT_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HIT_HOLD - 1);

    shot_state_t   state;
    logic [HW-1:0] hold_cnt;
    logic          tick;
    logic [11:0]   col;
    logic [IW-1:0] vivo_idx;
    logic          id_valid;
    logic [9:0]    spawn_x;
    logic [9:0]    spawn_y;
    logic          overlap;
    logic          at_bottom;
    logic [1:0]    lives_dec;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // A shooter row past its flat index wraps col to a huge value, so the
    // single col < COLS test also rejects X < COLS*Y.
    assign col      = 12'(ID_enemy_tiro_X) - 12'(COLS * int'(ID_enemy_tiro_Y));
    assign vivo_idx = IW'(ID_enemy_tiro_X);
    assign id_valid = (int'(ID_enemy_tiro_X) < WIDTH) && (int'(ID_enemy_tiro_Y) < ROWS) &&
                      (col < 12'(COLS)) && enemy_vivos[vivo_idx];

    assign spawn_x = 10'({1'b0, form_x} + 11'(int'(col) * SPACING_X) + 11'(ENEMY_W / 2));
    assign spawn_y = 10'({1'b0, form_y} + 11'(int'(ID_enemy_tiro_Y) * SPACING_Y) + 11'(ENEMY_H));

    assign overlap = ({1'b0, shot_x} + 11'(SHOT_W) > {1'b0, player_x}) &&
                     ({1'b0, shot_x} < {1'b0, player_x} + 11'(PLAYER_W)) &&
                     ({1'b0, shot_y} + 11'(SHOT_H) > 11'(PLAYER_Y)) &&
                     ({1'b0, shot_y} < 11'(PLAYER_Y + PLAYER_H));

    assign at_bottom = ({1'b0, shot_y} + 11'(SHOT_STEP) >= 11'(SCREEN_H));
    assign lives_dec = (lives == 2'd0) ? 2'd0 : lives - 2'd1;

    // Overlap is tested every cycle and outranks the tick, so a hit freezes
    // the shot at the position where contact was first seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            shot_active  <= 1'b0;
            shot_x       <= '0;
            shot_y       <= '0;
            hit_pulse    <= 1'b0;
            lives        <= 2'(LIVES);
            jogador_vivo <= 1'b1;
        end else if (restart) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            shot_active  <= 1'b0;
            shot_x       <= '0;
            shot_y       <= '0;
            hit_pulse    <= 1'b0;
            lives        <= 2'(LIVES);
            jogador_vivo <= 1'b1;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && id_valid) begin
                        shot_x      <= spawn_x;
                        shot_y      <= spawn_y;
                        shot_active <= 1'b1;
                        state       <= FLY;
                    end
                end
                FLY: begin
                    if (overlap) begin
                        state        <= HIT;
                        hit_pulse    <= 1'b1;
                        shot_active  <= 1'b0;
                        lives        <= lives_dec;
                        jogador_vivo <= (lives_dec != 2'd0);
                        hold_cnt     <= '0;
                    end else if (tick) begin
                        if (at_bottom) begin
                            state       <= IDLE;
                            shot_active <= 1'b0;
                        end else begin
                            shot_y <= shot_y + 10'(SHOT_STEP);
                        end
                    end
                end
                HIT: begin
                    if (lives == 2'd0) begin
                        state <= DEAD;
                    end else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                DEAD: begin
                    shot_active  <= 1'b0;
                    jogador_vivo <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_shot_ctrl.sv
// Scoreboard bench for enemy_shot_ctrl: stimulus queues the spawn/hit/miss
// events it expects and a negedge monitor matches what the DUT presents.
module tb_enemy_shot_ctrl;

    localparam int EV_SPAWN = 0;
    localparam int EV_HIT   = 1;
    localparam int EV_MISS  = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int lives;
        int vivo;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic [64:0] enemy_vivos = '1;
    logic [5:0]  id_x = '0;
    logic [5:0]  id_y = '0;
    logic [9:0]  form_x = 10'd20;
    logic [9:0]  form_y = 10'd40;
    logic [9:0]  player_x = 10'd60;
    logic        shot_active;
    logic [9:0]  shot_x;
    logic [9:0]  shot_y;
    logic        hit_pulse;
    logic [1:0]  lives;
    logic        jogador_vivo;

    ev_t exp_q[$];
    int  pass_count = 0;
    int  total_count = 0;
    bit  mon_en = 1'b0;
    int  prev_active = 0;
    int  prev_x = 0;
    int  prev_y = 0;

    enemy_shot_ctrl #(
        .TICK_DIV (2),
        .HIT_HOLD (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .restart         (restart),
        .enemy_vivos     (enemy_vivos),
        .ID_enemy_tiro_X (id_x),
        .ID_enemy_tiro_Y (id_y),
        .form_x          (form_x),
        .form_y          (form_y),
        .player_x        (player_x),
        .shot_active     (shot_active),
        .shot_x          (shot_x),
        .shot_y          (shot_y),
        .hit_pulse       (hit_pulse),
        .lives           (lives),
        .jogador_vivo    (jogador_vivo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sx, input int sy, input int px, input logic [64:0] vivos);
        id_x        = 6'(sx);
        id_y        = 6'(sy);
        player_x    = 10'(px);
        enemy_vivos = vivos;
    endtask

    task automatic expect_event(input int kind, input int x, input int y, input int lv, input int vv);
        ev_t e;
        e.kind  = kind;
        e.x     = x;
        e.y     = y;
        e.lives = lv;
        e.vivo  = vv;
        exp_q.push_back(e);
    endtask

    // Spawns are checked on the new position; hits and misses on the last
    // in-flight position held from the previous sample.
    task automatic observe(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_x", (kind == EV_SPAWN) ? int'(shot_x) : prev_x, e.x);
            checkOutput("event_y", (kind == EV_SPAWN) ? int'(shot_y) : prev_y, e.y);
            checkOutput("event_lives", int'(lives), e.lives);
            checkOutput("event_vivo", int'(jogador_vivo), e.vivo);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (shot_active && prev_active == 0) observe(EV_SPAWN);
            if (hit_pulse) observe(EV_HIT);
            if (!shot_active && prev_active == 1 && !hit_pulse) observe(EV_MISS);
            if (shot_active && prev_active == 1 && int'(shot_y) != prev_y)
                checkOutput("shot_step", int'(shot_y), prev_y + 4);
        end
        prev_active = int'(shot_active);
        prev_x      = int'(shot_x);
        prev_y      = int'(shot_y);
    end

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic count_quiet(input int cycles, input string name);
        int active_cycles = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (shot_active) active_cycles++;
        end
        checkOutput(name, active_cycles, 0);
    endtask

    initial begin
        logic [64:0] vivos_dead14;
        vivos_dead14     = '1;
        vivos_dead14[14] = 1'b0;

        applyStimulus(14, 1, 60, '1);
        repeat (2) @(negedge clk);
        checkOutput("reset_active", int'(shot_active), 0);
        checkOutput("reset_x", int'(shot_x), 0);
        checkOutput("reset_y", int'(shot_y), 0);
        checkOutput("reset_hit", int'(hit_pulse), 0);
        checkOutput("reset_lives", int'(lives), 3);
        checkOutput("reset_vivo", int'(jogador_vivo), 1);

        expect_event(EV_SPAWN, 72, 88, 3, 1);
        expect_event(EV_HIT, 72, 436, 2, 1);
        mon_en = 1'b1;
        reset  = 1'b0;
        wait_drain(1000, "first_hit_done");

        applyStimulus(14, 1, 300, '1);
        expect_event(EV_SPAWN, 72, 88, 2, 1);
        expect_event(EV_MISS, 72, 476, 2, 1);
        wait_drain(1000, "miss_done");
        expect_event(EV_SPAWN, 72, 88, 2, 1);
        wait_drain(100, "respawn_done");

        repeat (5) @(negedge clk);
        checkOutput("pre_reset_active", int'(shot_active), 1);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_active", int'(shot_active), 0);
        checkOutput("async_x", int'(shot_x), 0);
        checkOutput("async_y", int'(shot_y), 0);
        checkOutput("async_lives", int'(lives), 3);
        checkOutput("async_vivo", int'(jogador_vivo), 1);

        applyStimulus(10, 1, 60, '1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        count_quiet(20, "invalid_neg_col");
        applyStimulus(27, 1, 60, '1);
        count_quiet(20, "invalid_col_range");
        applyStimulus(14, 5, 60, '1);
        count_quiet(20, "invalid_row");
        applyStimulus(14, 1, 60, vivos_dead14);
        count_quiet(20, "dead_shooter");

        applyStimulus(14, 1, 60, '1);
        expect_event(EV_SPAWN, 72, 88, 3, 1);
        expect_event(EV_HIT, 72, 436, 2, 1);
        expect_event(EV_SPAWN, 72, 88, 2, 1);
        expect_event(EV_HIT, 72, 436, 1, 1);
        expect_event(EV_SPAWN, 72, 88, 1, 1);
        expect_event(EV_HIT, 72, 436, 0, 0);
        wait_drain(3000, "three_hits_done");
        count_quiet(40, "dead_no_spawn");
        checkOutput("dead_lives", int'(lives), 0);
        checkOutput("dead_vivo", int'(jogador_vivo), 0);

        applyStimulus(14, 1, 60, vivos_dead14);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checkOutput("restart_lives", int'(lives), 3);
        checkOutput("restart_vivo", int'(jogador_vivo), 1);
        checkOutput("restart_active", int'(shot_active), 0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
